sdram_cmd_seq: RTL and testbench
================================

# sdram_cmd_seq

Single-bank-at-a-time SDRAM command sequencer sitting between the host request port and the SDRAM pins. Arbitrates between host read/write requests and periodic refresh requests, then walks each access through ACTIVE, RAS-to-CAS delay, READ/WRITE, burst, PRECHARGE and precharge-recovery. Holds tRCD and tRP with internal down-counters loaded from run-time inputs, so the controller can retune timing without resynthesis.

## Interface
- ROW_W, 12, row address width
- COL_W, 8, column address width; must satisfy COL_W <= ROW_W and COL_W <= 10
- BURST_LEN, 4, data beats per access; range 1..8
- RFC_CYC, 7, NOP cycles after AUTO REFRESH; range 1..15

- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- req  in  1  host access request; held until req_ack
- req_wr  in  1  1 = write, 0 = read; sampled with req_ack
- req_addr  in  2+ROW_W+COL_W  {bank, row, col}; sampled with req_ack
- req_ack  out  1  one-cycle pulse: request accepted, ACTIVE issued this cycle
- rcd_max  in  2  tRCD wait, in NOP cycles, between ACTIVE and READ/WRITE
- rp_max  in  2  tRP wait, in NOP cycles, after PRECHARGE
- ref_req  in  1  refresh request level; held until ref_ack
- ref_ack  out  1  one-cycle pulse: AUTO REFRESH issued this cycle
- cs_n, ras_n, cas_n, we_n  out  1 each  registered SDRAM command
- sdr_ba  out  2  registered bank address
- sdr_a  out  ROW_W  registered address bus
- wr_beat  out  1  high on each write data beat
- rd_beat  out  1  high on each read command/burst beat; CAS latency is applied downstream
- busy  out  1  high whenever the block is not in IDLE

## Operation
- Command encoding {ras_n,cas_n,we_n}: NOP 111, ACTIVE 011, READ 101, WRITE 100, PRECHARGE 010 with sdr_a[10]=1 (all banks), AUTO REFRESH 001.
- States:
  - IDLE: NOP.
    - If ref_req: go to REF. Refresh has priority over req in the same cycle.
    - Else if req: go to ACT.
  - ACT: issue ACTIVE with the sampled bank and row; pulse req_ack; latch req_wr and the column; load the tRCD counter from rcd_max. Go to RCD.
  - RCD: NOP until the counter reaches 0, decrementing each cycle. With rcd_max=0, RCD is skipped and CMD follows ACT directly.
  - CMD: issue READ or WRITE with sdr_a = zero-extended column, sdr_a[10]=0. First beat.
  - BURST: NOP for BURST_LEN-1 cycles; one beat per cycle. Go to PRE.
  - PRE: issue PRECHARGE; load the tRP counter from rp_max.
  - RP: NOP until the counter reaches 0, then go to IDLE. With rp_max=0, IDLE follows PRE directly.
  - REF: issue AUTO REFRESH; pulse ref_ack; load the RFC counter with RFC_CYC.
  - RFC: NOP for RFC_CYC cycles, then go to IDLE.
- Counters are 2 bits (tRCD, tRP) and 4 bits (RFC). They saturate at 0 and never wrap.
- rcd_max and rp_max are sampled only at load time. Mid-wait changes have no effect.
- req and ref_req are ignored outside IDLE. A request raised mid-access waits for IDLE.
- wr_beat/rd_beat are high in CMD plus the BURST cycles: exactly BURST_LEN cycles.

## Timing
- Reset values: cs_n=1, ras_n=cas_n=we_n=1, sdr_ba=0, sdr_a=0, req_ack=0, ref_ack=0, wr_beat=rd_beat=0, busy=0, state IDLE.
- After reset release, cs_n=0 from the first clocked cycle onward.
- Reset asserted mid-access aborts at once; the next edge returns all outputs to their reset values. No PRECHARGE is issued.
- Latency, req high in IDLE to ACTIVE on the pins: 1 cycle.
- Total access length, ACTIVE through last tRP cycle: 1 + rcd_max + BURST_LEN + 1 + rp_max cycles; the next IDLE decision comes one cycle later.
- Refresh occupancy: 1 + RFC_CYC cycles.

## Configuration
- SDRAM_REFRESH_EN defined: ref_req arbitration and the REF/RFC states are compiled in.
- SDRAM_REFRESH_EN undefined: ref_req is ignored, ref_ack is tied 0, and the REF/RFC states are absent. The surrounding controller must refresh by other means.

## Test plan
- Reset, then idle for 5 cycles → cs_n=0, NOP on every cycle, busy=0, no acks.
- Read with bank=1, row=0x0A5, col=0x12, rcd_max=2, rp_max=1, BURST_LEN=4 → ACTIVE (sdr_ba=1, sdr_a=0x0A5), 2 NOPs, READ with sdr_a=0x012, 3 NOPs, PRECHARGE with sdr_a[10]=1, 1 NOP, then IDLE; rd_beat high for 4 cycles.
- Write with rcd_max=0 and rp_max=0 → WRITE on the cycle right after ACTIVE; wr_beat high for 4 cycles; total occupancy 6 cycles.
- req and ref_req asserted in the same IDLE cycle (refresh enabled, RFC_CYC=7) → AUTO REFRESH and ref_ack first, 7 NOPs, then ACTIVE with req_ack.
- req raised during RP and rcd_max changed during RCD → no ack until IDLE; the in-flight tRCD wait keeps its loaded value.
- Reset pulsed during BURST → next cycle all outputs at reset values; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/sdram_cmd_seq_if.sv
// Host-side request/refresh handshake for sdram_cmd_seq.
interface sdram_cmd_seq_if #(
  parameter int ROW_W = 12,
  parameter int COL_W = 8
);
  logic                   req;
  logic                   req_wr;
  logic [1+ROW_W+COL_W:0] req_addr;
  logic                   req_ack;
  logic                   ref_req;
  logic                   ref_ack;

  modport master (
    output req, req_wr, req_addr, ref_req,
    input  req_ack, ref_ack
  );

  modport slave (
    input  req, req_wr, req_addr, ref_req,
    output req_ack, ref_ack
  );
endinterface

// File: rtl/sdram_cmd_seq.sv
// SDRAM command sequencer: ACTIVE/RW/PRECHARGE walk with run-time tRCD/tRP.
// Define SDRAM_REFRESH_EN to compile in the AUTO REFRESH path.
module sdram_cmd_seq #(
  parameter int ROW_W     = 12,
  parameter int COL_W     = 8,
  parameter int BURST_LEN = 4,
  parameter int RFC_CYC   = 7
) (
  input  logic             Clk,
  input  logic             Reset,
  sdram_cmd_seq_if.slave   host,
  input  logic [1:0]       rcd_max,
  input  logic [1:0]       rp_max,
  output logic             cs_n,
  output logic             ras_n,
  output logic             cas_n,
  output logic             we_n,
  output logic [1:0]       sdr_ba,
  output logic [ROW_W-1:0] sdr_a,
  output logic             wr_beat,
  output logic             rd_beat,
  output logic             busy
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ACT   = 4'd1;
  localparam logic [3:0] S_RCD   = 4'd2;
  localparam logic [3:0] S_CMD   = 4'd3;
  localparam logic [3:0] S_BURST = 4'd4;
  localparam logic [3:0] S_PRE   = 4'd5;
  localparam logic [3:0] S_RP    = 4'd6;
`ifdef SDRAM_REFRESH_EN
  localparam logic [3:0] S_REF   = 4'd7;
  localparam logic [3:0] S_RFC   = 4'd8;
`endif

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
`ifdef SDRAM_REFRESH_EN
  localparam logic [2:0] C_REF = 3'b001;
`endif

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [1:0]       t_cnt;
  logic [2:0]       b_cnt;
  logic             wr_q;
  logic [1:0]       bank_q;
  logic [COL_W-1:0] col_q;

  logic [2:0]       cmd_nxt;
  logic [1:0]       ba_nxt;
  logic [ROW_W-1:0] a_nxt;
  logic             beat_nxt;
  logic             req_ack_nxt;
  logic             go_cmd;
  logic             go_pre;

  logic [1:0]       req_bank;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;

  assign req_bank = host.req_addr[1+ROW_W+COL_W -: 2];
  assign req_row  = host.req_addr[ROW_W+COL_W-1:COL_W];
  assign req_col  = host.req_addr[COL_W-1:0];

`ifdef SDRAM_REFRESH_EN
  logic [3:0] rfc_cnt;
  logic       ref_ack_nxt;
`else
  logic       ref_unused;
  assign ref_unused   = host.ref_req;
  assign host.ref_ack = 1'b0;
`endif

  // Outputs are decided from the next state so the pins are true flops.
  always_comb begin
    state_nxt   = state;
    cmd_nxt     = C_NOP;
    ba_nxt      = bank_q;
    a_nxt       = '0;
    beat_nxt    = 1'b0;
    req_ack_nxt = 1'b0;
    go_cmd      = 1'b0;
    go_pre      = 1'b0;
`ifdef SDRAM_REFRESH_EN
    ref_ack_nxt = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
`ifdef SDRAM_REFRESH_EN
        if (host.ref_req) begin
          state_nxt   = S_REF;
          cmd_nxt     = C_REF;
          ref_ack_nxt = 1'b1;
        end else
`endif
        if (host.req) begin
          state_nxt   = S_ACT;
          cmd_nxt     = C_ACT;
          ba_nxt      = req_bank;
          a_nxt       = req_row;
          req_ack_nxt = 1'b1;
        end
      end
      S_ACT: begin
        if (rcd_max == 2'd0) go_cmd = 1'b1;
        else state_nxt = S_RCD;
      end
      S_RCD: begin
        if (t_cnt <= 2'd1) go_cmd = 1'b1;
      end
      S_CMD: begin
        if (BURST_LEN == 1) begin
          go_pre = 1'b1;
        end else begin
          state_nxt = S_BURST;
          beat_nxt  = 1'b1;
        end
      end
      S_BURST: begin
        if (b_cnt <= 3'd1) go_pre = 1'b1;
        else beat_nxt = 1'b1;
      end
      S_PRE: begin
        state_nxt = (rp_max == 2'd0) ? S_IDLE : S_RP;
      end
      S_RP: begin
        if (t_cnt <= 2'd1) state_nxt = S_IDLE;
      end
`ifdef SDRAM_REFRESH_EN
      S_REF: begin
        state_nxt = S_RFC;
      end
      S_RFC: begin
        if (rfc_cnt <= 4'd1) state_nxt = S_IDLE;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (go_cmd) begin
      state_nxt = S_CMD;
      cmd_nxt   = wr_q ? C_WR : C_RD;
      a_nxt     = ROW_W'(col_q);
      beat_nxt  = 1'b1;
    end
    if (go_pre) begin
      state_nxt = S_PRE;
      cmd_nxt   = C_PRE;
      a_nxt[10] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state               <= S_IDLE;
      t_cnt               <= '0;
      b_cnt               <= '0;
      wr_q                <= 1'b0;
      bank_q              <= '0;
      col_q               <= '0;
      cs_n                <= 1'b1;
      {ras_n, cas_n, we_n} <= C_NOP;
      sdr_ba              <= '0;
      sdr_a               <= '0;
      wr_beat             <= 1'b0;
      rd_beat             <= 1'b0;
      busy                <= 1'b0;
      host.req_ack        <= 1'b0;
`ifdef SDRAM_REFRESH_EN
      rfc_cnt             <= '0;
      host.ref_ack        <= 1'b0;
`endif
    end else begin
      state               <= state_nxt;
      cs_n                <= 1'b0;
      {ras_n, cas_n, we_n} <= cmd_nxt;
      sdr_ba              <= ba_nxt;
      sdr_a               <= a_nxt;
      wr_beat             <= beat_nxt & wr_q;
      rd_beat             <= beat_nxt & ~wr_q;
      busy                <= (state_nxt != S_IDLE);
      host.req_ack        <= req_ack_nxt;
      if (req_ack_nxt) begin
        wr_q   <= host.req_wr;
        bank_q <= req_bank;
        col_q  <= req_col;
      end
      // Wait counters hold their remaining cycles and stop at zero.
      case (state)
        S_ACT:        t_cnt <= rcd_max;
        S_PRE:        t_cnt <= rp_max;
        S_RCD, S_RP:  if (t_cnt != 2'd0) t_cnt <= t_cnt - 2'd1;
        S_CMD:        b_cnt <= 3'(BURST_LEN - 1);
        S_BURST:      if (b_cnt != 3'd0) b_cnt <= b_cnt - 3'd1;
        default:      ;
      endcase
`ifdef SDRAM_REFRESH_EN
      host.ref_ack <= ref_ack_nxt;
      if (state == S_REF) rfc_cnt <= 4'(RFC_CYC);
      else if (state == S_RFC && rfc_cnt != 4'd0) rfc_cnt <= rfc_cnt - 4'd1;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_cmd_seq.sv
// Self-checking bench for sdram_cmd_seq: per-cycle schedule model
// plus directed literal checks and a randomized host.
module tb_sdram_cmd_seq;
  localparam int ROW_W = 12;
  localparam int COL_W = 8;
  localparam int BL    = 4;
  localparam int RFC   = 7;
  localparam int AW    = 2 + ROW_W + COL_W;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;

  localparam int T_NONE = 0;
  localparam int T_IDLE = 1;
  localparam int T_ACT  = 2;
  localparam int T_PRE  = 3;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [1:0]       rcd_max = 2'd0;
  logic [1:0]       rp_max = 2'd0;
  logic             cs_n, ras_n, cas_n, we_n;
  logic [1:0]       sdr_ba;
  logic [ROW_W-1:0] sdr_a;
  logic             wr_beat, rd_beat, busy;

  sdram_cmd_seq_if #(.ROW_W(ROW_W), .COL_W(COL_W)) host ();

  sdram_cmd_seq #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BURST_LEN(BL), .RFC_CYC(RFC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .host(host),
    .rcd_max(rcd_max), .rp_max(rp_max),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .sdr_ba(sdr_ba), .sdr_a(sdr_a),
    .wr_beat(wr_beat), .rd_beat(rd_beat), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]       cmd;
    logic             ck_ba;
    logic [1:0]       ba;
    logic [ROW_W-1:0] a_mask;
    logic [ROW_W-1:0] a;
    logic             req_ack;
    logic             ref_ack;
    logic             rd;
    logic             wr;
    logic             busy;
    int               tag;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  logic [1:0]       m_bank;
  logic [COL_W-1:0] m_col;
  logic             m_wr;

  int checks = 0;
  int failures = 0;
  bit rnd_on = 0;
  bit rnd_new = 0;

  int n, first_rd, last_ack, n_ack, n_ref, ref_step;
  int n_rd, n_wr, n_busy;
  logic [95:0]      cmdv;
  logic [ROW_W-1:0] act_a, col_a;
  logic [1:0]       act_ba;
  logic             pre_a10;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] c, input logic b);
    rec_t r;
    r.cmd = c; r.ck_ba = 1'b0; r.ba = '0;
    r.a_mask = '0; r.a = '0;
    r.req_ack = 1'b0; r.ref_ack = 1'b0;
    r.rd = 1'b0; r.wr = 1'b0; r.busy = b;
    r.tag = T_NONE;
    return r;
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r = mk(C_NOP, 1'b0);
    r.tag = T_IDLE;
    return r;
  endfunction

  task automatic push_act();
    rec_t r;
    m_bank = host.req_addr[AW-1 -: 2];
    m_col  = host.req_addr[COL_W-1:0];
    m_wr   = host.req_wr;
    r = mk(C_ACT, 1'b1);
    r.ck_ba = 1'b1; r.ba = m_bank;
    r.a_mask = '1; r.a = host.req_addr[ROW_W+COL_W-1:COL_W];
    r.req_ack = 1'b1; r.tag = T_ACT;
    q.push_back(r);
  endtask

  // tRCD NOPs, then BL beats starting with the column command, then PRE.
  task automatic push_body(input int rcd);
    rec_t r;
    for (int i = 0; i < rcd; i++) q.push_back(mk(C_NOP, 1'b1));
    for (int i = 0; i < BL; i++) begin
      r = mk(C_NOP, 1'b1);
      r.rd = !m_wr; r.wr = m_wr;
      if (i == 0) begin
        r.cmd = m_wr ? C_WR : C_RD;
        r.ck_ba = 1'b1; r.ba = m_bank;
        r.a_mask = '1; r.a = ROW_W'(m_col);
      end
      q.push_back(r);
    end
    r = mk(C_PRE, 1'b1);
    r.a_mask[10] = 1'b1; r.a = r.a_mask; r.tag = T_PRE;
    q.push_back(r);
  endtask

  task automatic push_rp(input int rp);
    for (int i = 0; i < rp; i++) q.push_back(mk(C_NOP, 1'b1));
  endtask

  task automatic push_ref();
    rec_t r;
    r = mk(C_REF, 1'b1);
    r.ref_ack = 1'b1;
    q.push_back(r);
    for (int i = 0; i < RFC; i++) q.push_back(mk(C_NOP, 1'b1));
  endtask

  task automatic trace_clear();
    n = 0; first_rd = 0; last_ack = 0; n_ack = 0; n_ref = 0; ref_step = 0;
    n_rd = 0; n_wr = 0; n_busy = 0; cmdv = '0;
    act_a = '0; col_a = '0; act_ba = '0; pre_a10 = 1'b0;
  endtask

  task automatic cmp();
    rec_t e;
    logic [2:0] c;
    @(negedge Clk);
    e = (q.size() > 0) ? q.pop_front() : idle_rec();
    c = {ras_n, cas_n, we_n};
    chk("cmd", c, e.cmd);
    chk("cs_n", cs_n, 1'b0);
    chk("req_ack", host.req_ack, e.req_ack);
    chk("ref_ack", host.ref_ack, e.ref_ack);
    chk("rd_beat", rd_beat, e.rd);
    chk("wr_beat", wr_beat, e.wr);
    chk("busy", busy, e.busy);
    if (e.ck_ba) chk("sdr_ba", sdr_ba, e.ba);
    if (e.a_mask != '0) chk("sdr_a", sdr_a & e.a_mask, e.a);
    n++;
    cmdv = {cmdv[92:0], c};
    if (host.req_ack) begin n_ack++; last_ack = n; end
    if (host.ref_ack) begin n_ref++; ref_step = n; end
    if (rd_beat) n_rd++;
    if (wr_beat) n_wr++;
    if (busy) n_busy++;
    if (c == C_ACT) begin act_a = sdr_a; act_ba = sdr_ba; end
    if ((c == C_RD || c == C_WR) && first_rd == 0) begin
      first_rd = n; col_a = sdr_a;
    end
    if (c == C_PRE) pre_a10 = sdr_a[10];
    if (e.req_ack) host.req = 1'b0;
    if (e.ref_ack) host.ref_req = 1'b0;
    cur = e;
  endtask

  task automatic model();
    bit taken;
    taken = 0;
    if (cur.tag == T_IDLE) begin
`ifdef SDRAM_REFRESH_EN
      if (host.ref_req) begin push_ref(); taken = 1; end
`endif
      if (!taken && host.req) push_act();
    end else if (cur.tag == T_ACT) begin
      push_body(int'(rcd_max));
    end else if (cur.tag == T_PRE) begin
      push_rp(int'(rp_max));
    end
  endtask

  task automatic rnd_drive();
    if (!host.req && rnd_new && $urandom_range(3) == 0) begin
      host.req = 1'b1;
      host.req_wr = 1'($urandom);
      host.req_addr = AW'($urandom);
    end
    if (!host.ref_req && rnd_new && $urandom_range(15) == 0)
      host.ref_req = 1'b1;
    if ($urandom_range(7) == 0) rcd_max = 2'($urandom);
    if ($urandom_range(7) == 0) rp_max = 2'($urandom);
  endtask

  task automatic step();
    cmp();
    if (rnd_on) rnd_drive();
    model();
  endtask

  task automatic drain();
    int k;
    bit pend;
    k = 0;
    pend = (q.size() > 0) || host.req;
`ifdef SDRAM_REFRESH_EN
    pend = pend || host.ref_req;
`endif
    while (pend && k < 400) begin
      step();
      k++;
      pend = (q.size() > 0) || host.req;
`ifdef SDRAM_REFRESH_EN
      pend = pend || host.ref_req;
`endif
    end
    chk("drain_done", pend, 1'b0);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_cs_n"}, cs_n, 1'b1);
    chk({tag, "_cmd"}, {ras_n, cas_n, we_n}, C_NOP);
    chk({tag, "_ba"}, sdr_ba, 2'd0);
    chk({tag, "_a"}, sdr_a, '0);
    chk({tag, "_acks"}, {host.req_ack, host.ref_ack}, 2'd0);
    chk({tag, "_beats"}, {rd_beat, wr_beat}, 2'd0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    host.req = 1'b0;
    host.req_wr = 1'b0;
    host.req_addr = '0;
    host.ref_req = 1'b0;
    cur = idle_rec();

    repeat (3) @(negedge Clk);
    rst_chk("por");
    Reset = 1'b0;

    // Idle after reset: NOPs, not busy, no acks.
    trace_clear();
    repeat (5) step();
    chk("idle_cmds", cmdv[14:0], 15'h7FFF);
    chk("idle_busy", n_busy, 0);
    chk("idle_acks", n_ack, 0);

    // Read: bank 1, row 0x0A5, col 0x12, tRCD 2, tRP 1.
    trace_clear();
    cmp();
    host.req = 1'b1; host.req_wr = 1'b0;
    host.req_addr = {2'd1, 12'h0A5, 8'h12};
    rcd_max = 2'd2; rp_max = 2'd1;
    model();
    repeat (10) step();
    chk("rd_seq", cmdv[32:0],
        33'b111_011_111_111_101_111_111_111_010_111_111);
    chk("rd_act_ba", act_ba, 2'd1);
    chk("rd_act_row", act_a, 12'h0A5);
    chk("rd_col", col_a, 12'h012);
    chk("rd_pre_a10", pre_a10, 1'b1);
    chk("rd_beats", n_rd, 4);
    chk("rd_busy", n_busy, 9);
    chk("rd_ack_step", last_ack, 2);
    drain();

    // Write with zero tRCD/tRP: six busy cycles.
    trace_clear();
    cmp();
    host.req = 1'b1; host.req_wr = 1'b1;
    host.req_addr = {2'd2, 12'h3FF, 8'hFF};
    rcd_max = 2'd0; rp_max = 2'd0;
    model();
    repeat (7) step();
    chk("wr_seq", cmdv[23:0], 24'b111_011_100_111_111_111_010_111);
    chk("wr_busy", n_busy, 6);
    chk("wr_beats", n_wr, 4);
    chk("wr_col", col_a, 12'h0FF);
    chk("wr_ba", act_ba, 2'd2);
    drain();

`ifdef SDRAM_REFRESH_EN
    // Refresh wins over a simultaneous request.
    trace_clear();
    cmp();
    host.req = 1'b1; host.req_wr = 1'b0;
    host.req_addr = {2'd3, 12'h001, 8'h02};
    host.ref_req = 1'b1;
    model();
    repeat (10) step();
    chk("ref_seq", cmdv[32:0],
        33'b111_001_111_111_111_111_111_111_111_111_011);
    chk("ref_ack_step", ref_step, 2);
    chk("ref_then_ack", last_ack, 11);
    drain();
`else
    // Without refresh support ref_req is ignored.
    trace_clear();
    cmp();
    host.ref_req = 1'b1;
    model();
    repeat (4) step();
    chk("noref_busy", n_busy, 0);
    chk("noref_ack", n_ref, 0);
    cmp();
    host.ref_req = 1'b0;
    model();
`endif

    // tRCD change mid-wait is ignored; a request during tRP waits.
    trace_clear();
    for (int i = 1; i <= 16; i++) begin
      cmp();
      if (i == 1) begin
        host.req = 1'b1; host.req_wr = 1'b0;
        host.req_addr = {2'd0, 12'h055, 8'h33};
        rcd_max = 2'd3; rp_max = 2'd3;
      end
      if (i == 3) rcd_max = 2'd0;
      if (i == 11) begin
        host.req = 1'b1; host.req_wr = 1'b1;
        host.req_addr = {2'd1, 12'h0AA, 8'h44};
      end
      model();
    end
    chk("mid_first_rd", first_rd, 6);
    chk("mid_n_ack", n_ack, 2);
    chk("mid_last_ack", last_ack, 15);
    drain();

    // Reset during the burst aborts at once.
    for (int i = 1; i <= 5; i++) begin
      cmp();
      if (i == 1) begin
        host.req = 1'b1; host.req_wr = 1'b0;
        host.req_addr = {2'd3, 12'h123, 8'h45};
        rcd_max = 2'd1; rp_max = 2'd1;
      end
      model();
    end
    Reset = 1'b1;
    @(negedge Clk);
    rst_chk("mid_rst");
    Reset = 1'b0;
    q.delete();
    cur = idle_rec();
    step();
    trace_clear();
    cmp();
    host.req = 1'b1; host.req_wr = 1'b1;
    host.req_addr = {2'd0, 12'h007, 8'h03};
    model();
    repeat (9) step();
    chk("post_rst_seq", cmdv[29:0],
        30'b111_011_111_100_111_111_111_010_111_111);
    chk("post_rst_ack", last_ack, 2);
    chk("post_rst_beats", n_wr, 4);
    drain();

    // Randomized host traffic against the schedule model.
    rnd_on = 1;
    rnd_new = 1;
    repeat (3000) step();
    rnd_new = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
